// File: rtl/risc_sequencer_pkg.sv
// Shared definitions for the accumulator-machine sequencer:
// opcode constants and the controller state encoding.
package risc_sequencer_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // FETCH must be the all-zero code so reset lands on it.
  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_IR_LOAD = 3'd1,
    S_DECODE  = 3'd2,
    S_OP_READ = 3'd3,
    S_OP_LOAD = 3'd4,
    S_EXEC    = 3'd5,
    S_STORE   = 3'd6,
    S_HALT    = 3'd7
  } state_e;

endpackage

// File: rtl/risc_sequencer.sv
// Fetch/decode/execute controller for the 8-opcode accumulator
// datapath; the ALU lives beside this block.
module risc_sequencer
  import risc_sequencer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [2:0]        alu_opcode,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              a_is_zero,
  output logic              halted,
  output logic [AWIDTH-1:0] pc
);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]  ir_q, ir_d;
  logic [WIDTH-1:0]  dr_q, dr_d;
  logic [WIDTH-1:0]  acc_q, acc_d;

  logic [2:0]        opcode;
  logic [AWIDTH-1:0] operand;

  assign opcode  = ir_q[WIDTH-1:WIDTH-3];
  assign operand = ir_q[AWIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      dr_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      dr_q    <= dr_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    dr_d     = dr_q;
    acc_d    = acc_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = pc_q;
    halted   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_rd  = 1'b1;
        state_d = S_IR_LOAD;
      end
      S_IR_LOAD: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + AWIDTH'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_HLT: state_d = S_HALT;
          OP_SKZ: begin
            if (a_is_zero) pc_d = pc_q + AWIDTH'(1);
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_d    = operand;
            state_d = S_FETCH;
          end
          OP_STO: state_d = S_STORE;
          OP_ADD, OP_AND,
          OP_XOR, OP_LDA: state_d = S_OP_READ;
        endcase
      end
      S_OP_READ: begin
        mem_rd   = 1'b1;
        mem_addr = operand;
        state_d  = S_OP_LOAD;
      end
      S_OP_LOAD: begin
        dr_d    = mem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        acc_d   = alu_out;
        state_d = S_FETCH;
      end
      S_STORE: begin
        mem_wr   = 1'b1;
        mem_addr = operand;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (go) state_d = S_FETCH;
      end
    endcase
  end

  assign mem_wdata  = acc_q;
  assign alu_opcode = opcode;
  assign alu_a      = acc_q;
  assign alu_b      = dr_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_risc_sequencer.sv
// Scoreboard bench: an instruction-level model predicts stores and
// halts with cycle stamps; a monitor compares them to the DUT.
module tb_risc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic [7:0] mem_rdata;
  logic [4:0] mem_addr;
  logic       mem_rd, mem_wr;
  logic [7:0] mem_wdata;
  logic [2:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       a_is_zero;
  logic       halted;
  logic [4:0] pc;

  risc_sequencer #(.WIDTH(8), .AWIDTH(5)) dut (
    .clk(clk), .rst(rst), .go(go),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .a_is_zero(a_is_zero),
    .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_opcode)
      3'd2:    alu_out = alu_a + alu_b;
      3'd3:    alu_out = alu_a & alu_b;
      3'd4:    alu_out = alu_a ^ alu_b;
      3'd5:    alu_out = alu_b;
      default: alu_out = alu_a;
    endcase
  end
  assign a_is_zero = (alu_a == 8'd0);

  logic [7:0] img [32];
  logic [7:0] mem [32];
  logic       load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= img[i];
    end else begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 1;
    else cyc <= cyc + 1;
  end

  typedef struct packed {
    logic        is_halt;
    logic [4:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } ev_t;

  ev_t        sbq [$];
  ev_t        tq [$];
  logic [4:0] hpcs [$];
  logic [7:0] mexp [32];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // Reference: executes instructions directly, charging the
  // per-opcode cycle cost; D is the idle gap before each resume.
  task automatic model(input int d, input int nh, output bit ok);
    logic [7:0] m [32];
    logic [4:0] p, opd;
    logic [7:0] acc, ir, b;
    logic [2:0] op;
    int c, halts;
    ev_t ev;
    for (int i = 0; i < 32; i++) m[i] = img[i];
    p = 0; acc = 0; c = 1; halts = 0; ok = 0;
    tq.delete(); hpcs.delete();
    for (int n = 0; n < 80 && !ok; n++) begin
      ir = m[p]; p = p + 5'd1;
      op = ir[7:5]; opd = ir[4:0];
      case (op)
        3'd0: begin
          ev = '{1'b1, p, acc, 32'(c + 3)};
          tq.push_back(ev); hpcs.push_back(p);
          halts++;
          if (halts == nh) ok = 1;
          c = c + 4 + d;
        end
        3'd1: begin
          if (acc == 0) p = p + 5'd1;
          c = c + 3;
        end
        3'd7: begin p = opd; c = c + 3; end
        3'd6: begin
          ev = '{1'b0, opd, acc, 32'(c + 3)};
          tq.push_back(ev);
          m[opd] = acc; c = c + 4;
        end
        default: begin
          b = m[opd];
          case (op)
            3'd2: acc = acc + b;
            3'd3: acc = acc & b;
            3'd4: acc = acc ^ b;
            default: acc = b;
          endcase
          c = c + 6;
        end
      endcase
    end
    for (int i = 0; i < 32; i++) mexp[i] = m[i];
  endtask

  logic       hprev = 1'b0;
  logic [4:0] hpc = 5'd0;
  ev_t        e;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
      if (mem_wr) begin
        if (sbq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("wr_kind", {31'd0, e.is_halt}, 32'd0);
          chk("wr_addr", {27'd0, mem_addr}, {27'd0, e.addr});
          chk("wr_data", {24'd0, mem_wdata}, {24'd0, e.data});
          chk("wr_cycle", cyc, e.cyc);
        end
      end
      if (halted && !hprev) begin
        if (sbq.size() == 0) chk("unexpected_halt", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          hpc = e.addr;
          chk("halt_kind", {31'd0, e.is_halt}, 32'd1);
          chk("halt_pc", {27'd0, pc}, {27'd0, e.addr});
          chk("halt_acc", {24'd0, alu_a}, {24'd0, e.data});
          chk("halt_cycle", cyc, e.cyc);
        end
      end else if (halted) begin
        chk("idle_bus", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("idle_pc", {27'd0, pc}, {27'd0, hpc});
      end
    end
    hprev = halted;
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic reset_load();
    rst = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("rst_rd", {31'd0, mem_rd}, 32'd1);
    chk("rst_addr", {27'd0, mem_addr}, 32'd0);
    chk("rst_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_acc_dr", {16'd0, alu_a, alu_b}, 32'd0);
  endtask

  task automatic run_prog(input int d, input int nh);
    bit ok;
    int t;
    model(d, nh, ok);
    reset_load();
    foreach (tq[i]) sbq.push_back(tq[i]);
    rst = 1'b0;
    for (int k = 1; k <= nh; k++) begin
      for (t = 0; t < 1000; t++) begin
        tick();
        if (halted) break;
      end
      if (t == 1000) begin
        chk("halt_timeout", 32'd1, 32'd0);
        break;
      end
      if (k < nh) begin
        repeat (d) tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("resume_fetch", {26'd0, mem_rd, mem_addr},
            {26'd0, 1'b1, hpcs[k-1]});
      end
    end
    tick();
    chk("queue_drained", sbq.size(), 32'd0);
    t = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== mexp[i]) t++;
    chk("final_memory", t, 32'd0);
    sbq.delete();
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
  endtask

  initial begin
    bit ok;
    int t, d, nh;

    clear_img();
    img[0] = 8'hAA; img[1] = 8'h4B; img[2] = 8'hCC; img[3] = 8'h00;
    img[10] = 8'h05; img[11] = 8'h03;
    run_prog(10, 2);
    chk("t1_mem12", {24'd0, mem[12]}, 32'h08);
    chk("t1_pc", {27'd0, pc}, 32'd5);

    clear_img();
    img[0] = 8'h20; img[1] = 8'h00; img[2] = 8'hE5;
    img[3] = 8'hAA; img[4] = 8'hAA; img[5] = 8'h00;
    run_prog(0, 1);
    chk("t2_pc", {27'd0, pc}, 32'd6);

    clear_img();
    img[0] = 8'hAA; img[1] = 8'h6B; img[2] = 8'h8C; img[3] = 8'h20;
    img[4] = 8'h00; img[5] = 8'h00;
    img[10] = 8'hF0; img[11] = 8'h3C; img[12] = 8'hFF;
    run_prog(1, 1);
    chk("t3_acc", {24'd0, alu_a}, 32'hCF);
    chk("t3_pc", {27'd0, pc}, 32'd5);

    clear_img();
    img[0] = 8'hFF; img[31] = 8'h00;
    run_prog(2, 2);
    chk("t4_pc_wrap", {27'd0, pc}, 32'd0);

    clear_img();
    img[0] = 8'hAA; img[1] = 8'hCC; img[2] = 8'h00;
    img[10] = 8'h05; img[12] = 8'h77;
    reset_load();
    rst = 1'b0;
    for (t = 0; t < 40; t++) begin
      tick();
      if (mem_wr) break;
    end
    chk("store_reached", {31'd0, mem_wr}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_store_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_store_pc_acc", {19'd0, pc, alu_a}, 32'd0);
    tick();
    chk("rst_store_mem", {24'd0, mem[12]}, 32'h77);
    run_prog(0, 1);
    chk("t5_mem12", {24'd0, mem[12]}, 32'h05);

    for (int n = 0; n < 20; n++) begin
      d = $urandom_range(0, 3);
      nh = $urandom_range(1, 2);
      ok = 0;
      for (int r = 0; r < 200 && !ok; r++) begin
        for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
        model(d, nh, ok);
      end
      if (ok) run_prog(d, nh);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/risc_sequencer.md
# risc_sequencer

Fetch/decode/execute controller for the 8-opcode accumulator datapath. It fetches instruction words from a synchronous single-port memory, decodes them, and drives the ALU opcode and operands. It writes ALU results back to the accumulator and handles stores, jumps, skip-on-zero and halt. It sits between the program/data memory and the ALU; the ALU's `alu_out` and `a_is_zero` are its only datapath inputs.

## Interface
- `WIDTH`, 8: data/instruction word width; must satisfy `WIDTH >= AWIDTH+3`
- `AWIDTH`, 5: memory address width; also PC width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `go`  in  1  resume strobe, sampled only in HALT
- `mem_rdata`  in  WIDTH  read data, valid the cycle after `mem_rd`
- `mem_addr`  out  AWIDTH  memory address
- `mem_rd`  out  1  read strobe
- `mem_wr`  out  1  write strobe
- `mem_wdata`  out  WIDTH  write data (= accumulator)
- `alu_opcode`  out  3  IR opcode field `ir[WIDTH-1:WIDTH-3]`
- `alu_a`  out  WIDTH  accumulator
- `alu_b`  out  WIDTH  data register
- `alu_out`  in  WIDTH  ALU result
- `a_is_zero`  in  1  ALU flag (accumulator == 0)
- `halted`  out  1  high while in HALT
- `pc`  out  AWIDTH  program counter

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. Operand address is `ir[AWIDTH-1:0]`.
- Registers: `pc`, `ir`, `dr` (data), `acc`, `state`. Reset: all zero, state FETCH.
- FETCH: `mem_rd`=1, `mem_addr`=pc -> IR_LOAD.
- IR_LOAD: `ir`<=`mem_rdata`; pc<=pc+1 -> DECODE.
- DECODE: by opcode
  - HLT -> HALT
  - SKZ: if `a_is_zero`, pc<=pc+1; -> FETCH
  - JMP: pc<=operand -> FETCH
  - STO -> STORE
  - ADD/AND/XOR/LDA -> OP_READ
- OP_READ: `mem_rd`=1, `mem_addr`=operand -> OP_LOAD.
- OP_LOAD: `dr`<=`mem_rdata` -> EXEC.
- EXEC: `acc`<=`alu_out` -> FETCH.
- STORE: `mem_wr`=1, `mem_addr`=operand, `mem_wdata`=acc -> FETCH.
- HALT: `halted`=1. `go`=1 -> FETCH with pc unchanged; otherwise stay.
- Strobes are decoded from `state` only; `mem_rd` and `mem_wr` are never high together.
- PC arithmetic is modulo 2^AWIDTH: 31+1 wraps to 0, and a skip from 31 lands on 0.
- `alu_opcode`/`alu_a`/`alu_b` are driven continuously from `ir`/`acc`/`dr`. LDA relies on the ALU passing `in_b`.

## Timing
- CPI: ADD/AND/XOR/LDA 6; STO 4; SKZ/JMP 3; HLT 3, then HALT.
- Memory read latency is exactly 1 cycle. There is no wait-state handshake.
- Reset:
  - `rst` takes effect immediately and mid-instruction, including during STORE.
  - `mem_wr` goes 0, `halted` 0, pc/acc/dr/ir 0.
  - During reset the state is FETCH, so `mem_rd`=1 and `mem_addr`=0. This read is harmless.
- First fetch completes on the first edge after `rst` deasserts.
- `a_is_zero` is sampled in DECODE and reflects the current `acc`.
- `go` is ignored outside HALT. `go` held high in HALT gives one resume per HALT entry.

## Structure
- Shared package: opcode constants (HLT..JMP) and state encoding.
- No sub-module. The ALU is instantiated beside this block at the core top level, not inside it.

## Test plan
- Program LDA 10 (0xAA), ADD 11 (0x4B), STO 12 (0xCC), HLT (0x00); mem[10]=0x05, mem[11]=0x03 -> write of 0x08 to addr 12 on cycle 16, `halted`=1 after 19 cycles, pc=4.
- acc=0 after reset; program SKZ (0x20), HLT, JMP 5 (0xE5), ..., addr5 HLT -> addr1 never fetched, halts with pc=6.
- LDA of 0xF0, AND with 0x3C -> acc=0x30; XOR with 0xFF -> acc=0xCF; SKZ then does not skip.
- JMP 31 (0xFF) with addr31=HLT -> pc wraps to 0 at halt; pulse `go` -> next fetch at addr 0.
- Assert `rst` during STORE -> `mem_wr` drops the same cycle; memory unchanged; pc=acc=0; execution restarts at addr 0.
- In HALT, hold `go`=0 for 10 cycles -> no `mem_rd`/`mem_wr` activity, pc stable.
